// File: rtl/apb_bus_pkg.sv
// ----------------------------------------------------------------------------
// apb_bus_pkg : shared FSM encoding, default address map and GPIO slot numbers.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package apb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
  localparam int unsigned DEF_SLV_SHIFT = 12;

  localparam int unsigned GPIOA = 0;
  localparam int unsigned GPIOB = 1;
  localparam int unsigned GPIOC = 2;
  localparam int unsigned GPIOD = 3;

endpackage

`default_nettype wire

// File: rtl/apb_addr_decoder.sv
// ----------------------------------------------------------------------------
// apb_addr_decoder : combinational region-hit and slot-index decode.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_addr_decoder
  import apb_bus_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned SLV_SHIFT = DEF_SLV_SHIFT
) (
  input  logic [31:0]                addr,
  output logic                       hit,
  output logic [$clog2(NUM_SLV)-1:0] idx
);

  localparam int unsigned IDX_W   = $clog2(NUM_SLV);
  localparam int unsigned TAG_LSB = SLV_SHIFT + IDX_W;

  assign hit = (addr >> TAG_LSB) == (BASE_ADDR >> TAG_LSB);
  assign idx = addr[SLV_SHIFT +: IDX_W];

endmodule

`default_nettype wire

// File: rtl/apb_bus_ctrl.sv
// ----------------------------------------------------------------------------
// apb_bus_ctrl : CPU data port to APB GPIO slots; APB_TIMEOUT_EN bounds ACCESS.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_bus_ctrl
  import apb_bus_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned SLV_SHIFT = DEF_SLV_SHIFT,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   err,
  output logic                   busy,
  output logic [NUM_SLV-1:0]     PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [SLV_SHIFT-1:0]   PADDR,
  output logic [31:0]            PWDATA,
  input  logic [NUM_SLV*32-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY,
  input  logic [NUM_SLV-1:0]     PSLVERR
);

  localparam int unsigned IDX_W = $clog2(NUM_SLV);

  if (NUM_SLV < 2 || TIMEOUT == 0) begin : g_bad_cfg
    $error("apb_bus_ctrl: NUM_SLV must be >= 2 and TIMEOUT >= 1");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             acc_done_d;
  logic             acc_err_d;
  logic [31:0]      acc_rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  logic [CNT_W-1:0] cnt_q;
`endif

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_dec (
    .addr (addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Completion of the ACCESS phase: selected slave ready, or the wait budget ran out.
  always_comb begin
    acc_done_d  = PREADY[idx_q];
    acc_err_d   = PSLVERR[idx_q];
    acc_rdata_d = PWRITE ? 32'd0 : PRDATA[idx_q*32 +: 32];
`ifdef APB_TIMEOUT_EN
    if (!PREADY[idx_q] && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
      acc_done_d  = 1'b1;
      acc_err_d   = 1'b1;
      acc_rdata_d = 32'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && dec_hit) begin
            state_q <= SETUP;
            idx_q   <= dec_idx;
            PSEL    <= {{(NUM_SLV-1){1'b0}}, 1'b1} << dec_idx;
            PWRITE  <= we;
            PADDR   <= addr[SLV_SHIFT-1:0];
            PWDATA  <= wdata;
            busy    <= 1'b1;
          end else if (req) begin
            state_q <= DONE;
            ready   <= 1'b1;
            err     <= 1'b1;
            rdata   <= '0;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        ACCESS: begin
          if (acc_done_d) begin
            state_q <= DONE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b1;
            err     <= acc_err_d;
            rdata   <= acc_rdata_d;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apb_bus_ctrl : directed transfers against a per-transfer timeline model.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_apb_bus_ctrl;

  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TMO  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              ready, err, busy;
  logic [NS-1:0]     PSEL;
  logic              PENABLE, PWRITE;
  logic [11:0]       PADDR;
  logic [31:0]       PWDATA;
  logic [NS*32-1:0]  PRDATA = '0;
  logic [NS-1:0]     PREADY = '0;
  logic [NS-1:0]     PSLVERR = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ready_cyc = -1;
  logic          chk_en = 1'b0;
  logic [NS-1:0] setup_psel = '0;
  logic [11:0]   setup_paddr = '0;

  // Expected outputs for the current cycle
  logic [NS-1:0] exp_psel = '0;
  logic          exp_pen = 1'b0, exp_busy = 1'b0, exp_ready = 1'b0, exp_err = 1'b0, exp_pwrite = 1'b0;
  logic [11:0]   exp_paddr = '0;
  logic [31:0]   exp_pwdata = '0, exp_rdata = '0;

  apb_bus_ctrl #(.NUM_SLV(NS), .BASE_ADDR(BASE), .SLV_SHIFT(12), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PSEL", 32'(PSEL), 32'(exp_psel));
      chk("PENABLE", 32'(PENABLE), 32'(exp_pen));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("ready", 32'(ready), 32'(exp_ready));
      if (exp_psel != '0) begin
        chk("PWRITE", 32'(PWRITE), 32'(exp_pwrite));
        chk("PADDR", 32'(PADDR), 32'(exp_paddr));
        chk("PWDATA", PWDATA, exp_pwdata);
      end
      if (exp_ready) begin
        chk("rdata", rdata, exp_rdata);
        chk("err", 32'(err), 32'(exp_err));
      end
      if (ready) ready_cyc = cyc;
      if (PSEL != '0 && !PENABLE) begin
        setup_psel  = PSEL;
        setup_paddr = PADDR;
      end
    end
  end

  // One CPU transfer; expectations come from the address map and the phase timeline.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                      input logic serr, input logic [31:0] prd, input int rst_after);
    logic          hit;
    int            slot;
    logic [NS-1:0] oh;
    logic          tmo;
    int            nacc;
    hit  = (a >= BASE) && ((a - BASE) < 32'(NS * 4096));
    slot = hit ? int'((a - BASE) / 4096) : 0;
    oh   = '0;
    if (hit) oh[slot] = 1'b1;
    tmo  = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo  = (waits >= TMO);
`endif
    nacc = tmo ? TMO : waits;
    start_cyc = cyc;
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int s = 0; s < NS; s++) PRDATA[s*32 +: 32] = (s == slot) ? prd : (~prd ^ 32'(s));
    PREADY = '0; PSLVERR = '0;
    @(posedge clk); #1;
    if (!hit) begin
      exp_ready = 1'b1; exp_err = 1'b1; exp_rdata = '0;
      @(posedge clk); #1;
      exp_ready = 1'b0; req = 1'b0;
      return;
    end
    exp_psel = oh; exp_pen = 1'b0; exp_busy = 1'b1;
    exp_pwrite = w; exp_paddr = a[11:0]; exp_pwdata = d;
    we = ~w; addr = ~a; wdata = ~d;
    @(posedge clk); #1;
    exp_pen = 1'b1;
    for (int i = 0; i < nacc; i++) begin
      if (i == rst_after) begin
        reset = 1'b0;
        exp_psel = '0; exp_pen = 1'b0; exp_busy = 1'b0; exp_ready = 1'b0;
        exp_err = 1'b0; exp_rdata = '0;
        #1;
        chk("async PSEL", 32'(PSEL), 32'd0);
        chk("async PENABLE", 32'(PENABLE), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; req = 1'b0; PREADY = '0; PSLVERR = '0;
        @(posedge clk); #1;
        return;
      end
      PREADY = ~oh; PSLVERR = ~oh;
      @(posedge clk); #1;
    end
    if (!tmo) begin
      PREADY = '1;
      PSLVERR = serr ? oh : ~oh;
      @(posedge clk); #1;
    end
    exp_psel = '0; exp_pen = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
    exp_err = tmo ? 1'b1 : serr;
    exp_rdata = (tmo || w) ? 32'd0 : prd;
    PREADY = '0; PSLVERR = '0;
    @(posedge clk); #1;
    exp_ready = 1'b0; req = 1'b0;
  endtask

  initial begin
    int s0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset PSEL", 32'(PSEL), 32'd0);
    chk("reset PENABLE", 32'(PENABLE), 32'd0);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset PADDR", 32'(PADDR), 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Single write, no wait states
    xfer(1'b1, 32'h1000_1008, 32'h0000_000F, 0, 1'b0, 32'h1234_5678, -1);
    chk("t1 setup PSEL", 32'(setup_psel), 32'h2);
    chk("t1 setup PADDR", 32'(setup_paddr), 32'h008);
    chk("t1 latency", 32'(ready_cyc - start_cyc), 32'd3);
    chk("t1 err held", 32'(err), 32'd0);

    // Read with three wait states
    xfer(1'b0, 32'h1000_2004, 32'h0, 3, 1'b0, 32'h0000_000A, -1);
    chk("t2 latency", 32'(ready_cyc - start_cyc), 32'd6);
    chk("t2 rdata held", rdata, 32'h0000_000A);

    // Decode misses, including just past the last slot and just below the base
    setup_psel = '0;
    xfer(1'b0, 32'h2000_0000, 32'h0, 0, 1'b0, 32'h5555_5555, -1);
    chk("t3 latency", 32'(ready_cyc - start_cyc), 32'd1);
    chk("t3 err", 32'(err), 32'd1);
    chk("t3 rdata", rdata, 32'd0);
    chk("t3 no PSEL", 32'(setup_psel), 32'd0);
    xfer(1'b0, 32'h1000_4000, 32'h0, 0, 1'b0, 32'h1, -1);
    xfer(1'b1, 32'h0FFF_FFFC, 32'h3, 0, 1'b0, 32'h1, -1);

    // Slave error on slot 3 while other slots pulse PREADY
    xfer(1'b0, 32'h1000_3000, 32'h0, 2, 1'b1, 32'h0000_BEEF, -1);
    chk("t4 err", 32'(err), 32'd1);
    chk("t4 rdata", rdata, 32'h0000_BEEF);

    // Top of the last slot, then back-to-back transfers
    xfer(1'b0, 32'h1000_3FFC, 32'h0, 1, 1'b0, 32'h0D0D_0D0D, -1);
    s0 = cyc;
    xfer(1'b1, 32'h1000_0100, 32'hA5A5_5A5A, 0, 1'b0, 32'h0, -1);
    xfer(1'b0, 32'h1000_1FF0, 32'h0, 0, 1'b0, 32'h600D_F00D, -1);
    chk("b2b spacing", 32'(start_cyc - s0), 32'd4);
    chk("b2b rdata", rdata, 32'h600D_F00D);

    // Reset in the middle of ACCESS, then a normal transfer
    xfer(1'b0, 32'h1000_0010, 32'h0, 5, 1'b0, 32'h77, 2);
    chk("t5 rdata cleared", rdata, 32'd0);
    xfer(1'b0, 32'h1000_0014, 32'h0, 1, 1'b0, 32'h0000_CAFE, -1);
    chk("t5 recovery rdata", rdata, 32'h0000_CAFE);

    // Long stall: aborts at the wait budget, or waits it out
    xfer(1'b0, 32'h1000_1000, 32'h0, 120, 1'b0, 32'h99, -1);
`ifdef APB_TIMEOUT_EN
    chk("t6 timeout latency", 32'(ready_cyc - start_cyc), 32'd18);
    chk("t6 timeout err", 32'(err), 32'd1);
`else
    chk("t6 long latency", 32'(ready_cyc - start_cyc), 32'd123);
    chk("t6 long rdata", rdata, 32'h99);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
